// File: rtl/nodf_handshake_tracker_pkg.sv
// Shared types for the ap_ctrl_hs handshake tracker: tracker state encoding
// and the default counter width.
package nodf_hs_pkg;

  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2,
    FINISHED  = 2'd3
  } hs_state_e;

endpackage

// File: rtl/nodf_handshake_tracker_sat_counter.sv
// Saturating up-counter with freeze input and synchronous clear.
module sat_counter
  import nodf_hs_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= CNT_ZERO;
    end else if (inc && !freeze && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/nodf_handshake_tracker.sv
// Passive monitor of one HLS kernel's ap_ctrl_hs handshake: tracks transaction
// state, counts starts/completions/busy/stall cycles and measures latency.
module nodf_handshake_tracker
  import nodf_hs_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_count,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] last_latency,
  output logic             err_done_no_start,
  output logic             err_ready_no_start,
  output logic             finished
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  hs_state_e        cur_state;
  hs_state_e        nxt_state;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] lat_inc;
  logic             frozen;
  logic             accept;
  logic             start_txn;
  logic             complete;
  logic             busy_tick;
  logic             stall_tick;
  logic             err_done_ev;
  logic             err_ready_ev;

  assign state = cur_state;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; finish wins after this cycle's events are taken.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (ap_start && ap_done && ap_continue) nxt_state = IDLE;
        else if (ap_start && ap_done)           nxt_state = DONE_WAIT;
        else if (ap_start)                      nxt_state = BUSY;
        else                                    nxt_state = IDLE;
      end
      BUSY: begin
        if (ap_done && ap_continue) nxt_state = IDLE;
        else if (ap_done)           nxt_state = DONE_WAIT;
        else                        nxt_state = BUSY;
      end
      DONE_WAIT: begin
        if (ap_continue) nxt_state = IDLE;
        else             nxt_state = DONE_WAIT;
      end
      FINISHED: nxt_state = FINISHED;
      default:  nxt_state = IDLE;
    endcase
    if (finish && (cur_state != FINISHED)) begin
      nxt_state = FINISHED;
    end else begin
      nxt_state = nxt_state;
    end
  end

  // Per-cycle event decode.
  always_comb begin
    frozen       = (cur_state == FINISHED);
    accept       = !frozen && ap_start && ap_ready;
    stall_tick   = !frozen && ap_done && !ap_continue;
    err_ready_ev = !frozen && ap_ready && !ap_start;
    start_txn    = 1'b0;
    complete     = 1'b0;
    busy_tick    = 1'b0;
    err_done_ev  = 1'b0;
    case (cur_state)
      IDLE: begin
        start_txn   = ap_start;
        complete    = ap_start && ap_done && ap_continue;
        err_done_ev = ap_done && !ap_start;
      end
      BUSY: begin
        busy_tick = 1'b1;
        complete  = ap_done && ap_continue;
      end
      DONE_WAIT: begin
        busy_tick = 1'b1;
        complete  = ap_continue;
      end
      FINISHED: begin
        start_txn = 1'b0;
      end
      default: begin
        start_txn = 1'b0;
      end
    endcase
    lat_inc = (lat_cnt == CNT_MAX) ? CNT_MAX : (lat_cnt + CNT_ONE);
  end

  // Latency counter counts the start cycle as 1; last_latency includes the completion cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt      <= CNT_ZERO;
      last_latency <= CNT_ZERO;
    end else if (start_txn) begin
      lat_cnt      <= CNT_ONE;
      last_latency <= complete ? CNT_ONE : last_latency;
    end else if (busy_tick) begin
      lat_cnt      <= lat_inc;
      last_latency <= complete ? lat_inc : last_latency;
    end else begin
      lat_cnt      <= lat_cnt;
      last_latency <= last_latency;
    end
  end

  // Sticky protocol-error and finished flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_done_no_start  <= 1'b0;
      err_ready_no_start <= 1'b0;
      finished           <= 1'b0;
    end else begin
      err_done_no_start  <= err_done_no_start  | err_done_ev;
      err_ready_no_start <= err_ready_no_start | err_ready_ev;
      finished           <= finished | (finish && !frozen);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_start_cnt (
    .clock(clock), .reset(reset), .inc(accept), .freeze(frozen), .count(start_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_done_cnt (
    .clock(clock), .reset(reset), .inc(complete), .freeze(frozen), .count(done_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
    .clock(clock), .reset(reset), .inc(busy_tick), .freeze(frozen), .count(busy_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset), .inc(stall_tick), .freeze(frozen), .count(stall_cycles)
  );

endmodule

// File: tb/tb_nodf_handshake_tracker.sv
// Directed bench for nodf_handshake_tracker: expectations are queued per step
// and popped against the registered outputs one time unit after each edge.
module tb_nodf_handshake_tracker;

  logic        clock;
  logic        reset;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_continue;
  logic        finish;
  logic [1:0]  state;
  logic [31:0] start_count;
  logic [31:0] done_count;
  logic [31:0] busy_cycles;
  logic [31:0] stall_cycles;
  logic [31:0] last_latency;
  logic        err_done_no_start;
  logic        err_ready_no_start;
  logic        finished;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  nodf_handshake_tracker #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_count(start_count), .done_count(done_count),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
    .last_latency(last_latency), .err_done_no_start(err_done_no_start),
    .err_ready_no_start(err_ready_no_start), .finished(finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return {30'd0, state};
      1:       return start_count;
      2:       return done_count;
      3:       return busy_cycles;
      4:       return stall_cycles;
      5:       return last_latency;
      6:       return {31'd0, err_done_no_start};
      7:       return {31'd0, err_ready_no_start};
      8:       return {31'd0, finished};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0:       return "state";
      1:       return "start_count";
      2:       return "done_count";
      3:       return "busy_cycles";
      4:       return "stall_cycles";
      5:       return "last_latency";
      6:       return "err_done_no_start";
      7:       return "err_ready_no_start";
      8:       return "finished";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all(string tag, logic [1:0] st, int sc, int dc, int bc,
                            int stc, int lat, logic edn, logic ern, logic fin);
    push(tag, 0, {30'd0, st});
    push(tag, 1, sc);
    push(tag, 2, dc);
    push(tag, 3, bc);
    push(tag, 4, stc);
    push(tag, 5, lat);
    push(tag, 6, {31'd0, edn});
    push(tag, 7, {31'd0, ern});
    push(tag, 8, {31'd0, fin});
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      n_tests++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s.%s: observed %0d expected %0d", e.tag, sel_name(e.sel), obs, e.val);
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(logic s, logic r, logic d, logic c, logic f);
    ap_start    = s;
    ap_ready    = r;
    ap_done     = d;
    ap_continue = c;
    finish      = f;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    reset = 1'b0;

    // Reset state after 5 idle cycles
    expect_all("reset_idle", 2'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(5);
    check_sb();

    // Basic transaction: start at t0, done at t0+4 -> latency 5, busy 4
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    push("basic_t0", 0, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    check_sb();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_all("basic_done", 2'd0, 1, 1, 4, 0, 5, 1'b0, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_sb();

    // Stall: continue low for 3 cycles of ap_done, then high
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push("stall_wait", 0, 32'd2);
      tick(1);
      check_sb();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_all("stall_done", 2'd0, 1, 1, 7, 3, 8, 1'b0, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_sb();

    // Single-cycle transaction in IDLE
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_all("one_cycle", 2'd0, 1, 1, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_sb();

    // Protocol errors are sticky and count nothing
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_all("errors_set", 2'd0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    check_sb();
    tick(3);
    push("errors_hold", 6, 32'd1);
    push("errors_hold", 7, 32'd1);
    check_sb();
    do_reset();
    push("errors_clr", 6, 32'd0);
    push("errors_clr", 7, 32'd0);
    check_sb();

    // finish coincident with completion: event counted, then frozen
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_all("finish_edge", 2'd3, 1, 1, 3, 0, 4, 1'b0, 1'b0, 1'b1);
    tick(1);
    check_sb();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_all("frozen", 2'd3, 1, 1, 3, 0, 4, 1'b0, 1'b0, 1'b1);
    check_sb();
    do_reset();
    expect_all("post_reset", 2'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_sb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
